// File: rtl/hdmi_timing_ctrl.sv
// hdmi_timing_ctrl: free-running raster timing generator feeding three TMDS encoders.
// Latency: counters -> pix_req/pix_x/pix_y/frame_start/line_start 1 cycle; pix_req -> vde/cd_blue 1 cycle.
// Backpressure: none; dropping en lets the current frame finish (DRAIN) before stopping in IDLE.
//
// Ports:
//   pixclk      pixel clock, all registers update on its rising edge
//   rst_n       synchronous active-low reset
//   en          request to run video timing
//   pix_req     pixel fetch strobe, one cycle ahead of vde
//   pix_x/pix_y fetch column/row, zero when pix_req=0
//   frame_start one-cycle pulse at counter position (0,0), aligned with pix_req
//   line_start  one-cycle pulse at the start of each active line, aligned with pix_req
//   vde         video data enable for all three encoders
//   cd_blue     {vsync, hsync} control data for the blue-channel encoder
//   cd_other    control data for red/green encoders, always 2'b00
//   busy        high whenever the generator is not idle
//
// H_TOTAL and V_TOTAL must each be at most 1024 so they fit the 10-bit counters.
module hdmi_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic       pixclk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_req,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_start,
  output logic       line_start,
  output logic       vde,
  output logic [1:0] cd_blue,
  output logic [1:0] cd_other,
  output logic       busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [1:0] CD_IDLE  = {~VS_POL, ~HS_POL};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [9:0] s1_hcnt;
  logic [9:0] s1_vcnt;
  logic       at_last;
  logic       running;
  logic       active;
  logic       hs_on;
  logic       vs_on;

  assign at_last = (hcnt == H_LAST) && (vcnt == V_LAST);

  // State register
  always_ff @(posedge pixclk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; en has priority over the drain exit so a re-raise on the
  // final pixel keeps running with a normal wrap.
  always_comb begin
    state_nxt = state;
    running   = 1'b1;
    case (state)
      IDLE: begin
        running = 1'b0;
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (!en) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (en)           state_nxt = RUN;
        else if (at_last) state_nxt = IDLE;
      end
      default: begin
        running   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = running;

  // Raster counters; held at the origin while idle so every start is a fresh frame.
  always_ff @(posedge pixclk) begin
    if (!rst_n || !running) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  assign active = running && (hcnt < H_ACT) && (vcnt < V_ACT);

  // Stage 1: fetch. s1_hcnt/s1_vcnt carry the raw position so stage 2 can
  // decode sync even though pix_x/pix_y are zeroed in blanking.
  always_ff @(posedge pixclk) begin
    if (!rst_n) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      s1_hcnt     <= '0;
      s1_vcnt     <= '0;
    end else begin
      pix_req     <= active;
      pix_x       <= active ? hcnt : 10'd0;
      pix_y       <= active ? vcnt : 10'd0;
      frame_start <= running && (hcnt == 10'd0) && (vcnt == 10'd0);
      line_start  <= running && (hcnt == 10'd0) && (vcnt < V_ACT);
      s1_hcnt     <= hcnt;
      s1_vcnt     <= vcnt;
    end
  end

  assign hs_on = (s1_hcnt >= HS_FIRST) && (s1_hcnt <= HS_LAST);
  assign vs_on = (s1_vcnt >= VS_FIRST) && (s1_vcnt <= VS_LAST);

  // Stage 2: encode. Forced to the blanking pattern while idle.
  always_ff @(posedge pixclk) begin
    if (!rst_n || !running) begin
      vde     <= 1'b0;
      cd_blue <= CD_IDLE;
    end else begin
      vde     <= pix_req;
      cd_blue <= {vs_on ? VS_POL : ~VS_POL, hs_on ? HS_POL : ~HS_POL};
    end
  end

  assign cd_other = 2'b00;

endmodule
